// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: 8 lines x 32 bytes.
// The cache data lives in an external synchronous SRAM. Misses go to SDRAM over a byte-wide strobe port.
module cache_controller #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr_rd,
  input  logic        cpu_cs,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [7:0]  sram_addr,
  output logic [7:0]  sram_din,
  output logic        sram_wen,
  input  logic [7:0]  sram_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr_rd,
  output logic        mem_mstrb,
  input  logic [7:0]  mem_dout
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, COMPARE, WB_RD, WB_STB, WB_WAIT, AL_STB, AL_WAIT, ACCESS, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          cs_q;
  logic [15:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [7:0]    data_q, data_d;
  logic [4:0]    k_q, k_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [7:0]    cpu_din_q, cpu_din_d;
  logic [7:0]    tag_q [8];
  logic [7:0]    tag_d [8];
  logic [7:0]    valid_q, valid_d;
  logic [7:0]    dirty_q, dirty_d;

  logic [7:0] req_tag;
  logic [2:0] req_idx;
  logic [4:0] req_off;
  logic       lat_done;

  assign req_tag  = addr_q[15:8];
  assign req_idx  = addr_q[7:5];
  assign req_off  = addr_q[4:0];
  assign lat_done = (lat_q == LAT_LAST);
  assign cpu_din  = cpu_din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_q      <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      k_q       <= '0;
      lat_q     <= '0;
      cpu_din_q <= '0;
      tag_q     <= '{default: '0};
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cpu_cs;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      k_q       <= k_d;
      lat_q     <= lat_d;
      cpu_din_q <= cpu_din_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    data_d    = data_q;
    k_d       = k_q;
    lat_d     = lat_q;
    cpu_din_d = cpu_din_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    cpu_rdy   = (state_q == IDLE);
    sram_addr = '0;
    sram_din  = '0;
    sram_wen  = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_wr_rd = 1'b0;
    mem_mstrb = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a fresh rising edge of cs starts work; a held-high cs is ignored.
        if (cpu_cs && !cs_q) begin
          addr_d  = cpu_addr;
          wr_d    = cpu_wr_rd;
          data_d  = cpu_dout;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        k_d = '0;
        if (valid_q[req_idx] && tag_q[req_idx] == req_tag)
          state_d = ACCESS;
        else if (valid_q[req_idx] && dirty_q[req_idx])
          state_d = WB_RD;
        else
          state_d = AL_STB;
      end
      WB_RD: begin
        sram_addr = {req_idx, k_q};
        state_d   = WB_STB;
      end
      WB_STB: begin
        mem_mstrb = 1'b1;
        mem_wr_rd = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, k_q};
        mem_din   = sram_dout;
        lat_d     = '0;
        state_d   = WB_WAIT;
      end
      WB_WAIT: begin
        if (lat_done) begin
          k_d     = k_q + 5'd1;
          state_d = (k_q == 5'd31) ? AL_STB : WB_RD;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      AL_STB: begin
        mem_mstrb = 1'b1;
        mem_addr  = {req_tag, req_idx, k_q};
        lat_d     = '0;
        state_d   = AL_WAIT;
      end
      AL_WAIT: begin
        if (lat_done) begin
          // mem_dout is valid only in this last wait cycle.
          sram_wen  = 1'b1;
          sram_addr = {req_idx, k_q};
          sram_din  = mem_dout;
          k_d       = k_q + 5'd1;
          if (k_q == 5'd31) begin
            tag_d[req_idx]   = req_tag;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            state_d          = ACCESS;
          end else begin
            state_d = AL_STB;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ACCESS: begin
        sram_addr = {req_idx, req_off};
        if (wr_q) begin
          sram_wen         = 1'b1;
          sram_din         = data_q;
          dirty_d[req_idx] = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!wr_q)
          cpu_din_d = sram_dout;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
